tx_uart_128: RTL and testbench

Serial transmitter for the 128-bit UART link: accepts a 128-bit word, splits it into 16 bytes and sends each byte as an 8N1 frame on a single line. It is the sending end paired with the 128-bit receiver. Byte order matches the receiver's left-shift assembly: byte `data_in[127:120]` is sent first and `data_in[7:0]` last. A looped-back receiver therefore reproduces `data_in` exactly.

---
 rtl/uart_pkg.sv | 16 +
 rtl/tx_uart_128_if.sv | 12 +
 rtl/uart_byte_tx.sv | 99 +++++++++
 rtl/tx_uart_128.sv | 53 +++++
 tb/tb_tx_uart_128.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and framing constants
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_FRAME_BITS   = 10;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_WORD_BYTES   = 16;
  localparam int UART_CLKS_PER_BIT = 868;

endpackage

// File: rtl/tx_uart_128_if.sv
// rtl/tx_uart_128_if.sv - request/line signals of the 128-bit UART transmitter
interface tx_uart_128_if;
  logic         en_tx;
  logic         start;
  logic [127:0] data_in;
  logic         u_tx;
  logic         busy;
  logic         u_tx_done;

  modport master (output en_tx, start, data_in, input u_tx, busy, u_tx_done);
  modport slave  (input en_tx, start, data_in, output u_tx, busy, u_tx_done);
endinterface

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - single-byte 8N1 serializer; chains frames when start is held at frame end
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      start,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      tx,
  output logic                      busy,
  output logic                      done,
  output logic                      frame_end
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_t       state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic              bit_end;

  assign bit_end   = (baud == BAUD_LAST);
  assign frame_end = (state == ST_STOP) && bit_end;

  // data is read live (not latched): the owner must hold it stable for the whole frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (!en) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_START;
            baud  <= '0;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= data[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (start) begin
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/tx_uart_128.sv
// rtl/tx_uart_128.sv - sends a 128-bit word as 16 back-to-back 8N1 frames, MSB byte first
module tx_uart_128
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic         clk,
  input  logic         reset,
  tx_uart_128_if.slave bus
);
  localparam logic [3:0] LAST_BYTE = 4'(UART_WORD_BYTES - 1);

  logic [127:0] shreg;
  logic [3:0]   byte_cnt;
  logic         accept;
  logic         last_byte;
  logic         byte_start;
  logic         frame_end;

  assign accept    = bus.en_tx && bus.start && !bus.busy;
  assign last_byte = (byte_cnt == LAST_BYTE);
  // while busy, start only matters at frame end: it chains the next byte with no gap
  assign byte_start = bus.busy ? !last_byte : bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (!bus.en_tx) begin
      byte_cnt <= '0;
    end else if (accept) begin
      shreg    <= bus.data_in;
      byte_cnt <= '0;
    end else if (frame_end && !last_byte) begin
      shreg    <= {shreg[119:0], 8'h00};
      byte_cnt <= byte_cnt + 4'd1;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en_tx),
    .start    (byte_start),
    .data     (shreg[127:120]),
    .tx       (bus.u_tx),
    .busy     (bus.busy),
    .done     (bus.u_tx_done),
    .frame_end(frame_end)
  );
endmodule

// File: tb/tb_tx_uart_128.sv
// tb/tb_tx_uart_128.sv - directed self-checking bench for tx_uart_128
module tb_tx_uart_128;
  localparam int C = 4;
  localparam int WORD_CYC = 160 * C;

  localparam logic [127:0] W1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W2 = 128'hA5C30F1E_2D3C4B5A_69788796_A5B4C3D2;
  localparam logic [127:0] W3 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] W4 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
  localparam logic [127:0] W5 = 128'h00FF00FF_11223344_55667788_99AABBCC;
  localparam logic [127:0] W6 = 128'h80000000_00000000_00000000_00000001;
  // line levels for 0xA5 then the next start bit, 4 cycles per level, cycle 0 in bit 0
  localparam logic [43:0] A5_TRACE = 44'h0FF0F00F0F0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [127:0] got;
  logic [43:0]  trace;
  int           bad;

  tx_uart_128_if bus ();

  tx_uart_128 #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the first cycle after acceptance; returns at the cycle right after the word.
  task automatic run_word(input bit inject, output logic [127:0] word, output logic [43:0] tr,
                          output int anomalies);
    word = '0;
    tr = '0;
    anomalies = 0;
    for (int k = 0; k < WORD_CYC; k++) begin
      int f;
      int b;
      f = k / (10 * C);
      b = (k / C) % 10;
      if (k < 44) tr[k] = bus.u_tx;
      if (bus.busy !== 1'b1 || bus.u_tx_done !== 1'b0) anomalies++;
      if (k % C == C / 2) begin
        if (b == 0 && bus.u_tx !== 1'b0) anomalies++;
        else if (b == 9 && bus.u_tx !== 1'b1) anomalies++;
        else if (b >= 1 && b <= 8) word[120 - 8 * f + b - 1] = bus.u_tx;
      end
      if (inject && k == 50) begin
        bus.data_in = '1;
        bus.start = 1'b1;
      end
      if (inject && k == 51) bus.start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [127:0] w);
    bus.data_in = w;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, bus.u_tx_done, 1'b1);
    check({tag, "_busy0"}, bus.busy, 1'b0);
    check({tag, "_utx1"}, bus.u_tx, 1'b1);
  endtask

  initial begin
    bus.en_tx = 1'b1;
    bus.start = 1'b1;
    bus.data_in = W1;

    repeat (3) begin
      @(negedge clk);
      check("rst_utx", bus.u_tx, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.u_tx_done, 1'b0);
    end
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_utx", bus.u_tx, 1'b1);

    send(W1);
    check("w1_busy_rise", bus.busy, 1'b1);
    check("w1_start_bit", bus.u_tx, 1'b0);
    run_word(1'b0, got, trace, bad);
    check("w1_anomalies", 128'(bad), 128'd0);
    check("w1_word", got, W1);
    check("w1_byte0_zero", got[127:120], 8'h00);
    check("w1_frame0_line", trace[35:4], 32'h0);
    check_done("w1");

    // start in the done cycle must be accepted
    send(W2);
    check("w2_busy_rise", bus.busy, 1'b1);
    run_word(1'b1, got, trace, bad);
    check("w2_anomalies", 128'(bad), 128'd0);
    check("w2_word", got, W2);
    check("w2_a5_trace", trace, A5_TRACE);
    check_done("w2");

    @(negedge clk);
    send(W3);
    repeat (100) @(negedge clk);
    bus.en_tx = 1'b0;
    @(negedge clk);
    check("abort_utx", bus.u_tx, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    bad = 0;
    for (int k = 0; k < 700; k++) begin
      if (bus.u_tx_done !== 1'b0 || bus.busy !== 1'b0 || bus.u_tx !== 1'b1) bad++;
      @(negedge clk);
    end
    check("abort_quiet", 128'(bad), 128'd0);
    bus.en_tx = 1'b1;
    @(negedge clk);
    send(W4);
    check("w4_busy_rise", bus.busy, 1'b1);
    run_word(1'b0, got, trace, bad);
    check("w4_anomalies", 128'(bad), 128'd0);
    check("w4_word", got, W4);
    check_done("w4");

    @(negedge clk);
    send(W5);
    repeat (6) @(negedge clk);
    check("w5_data_low", bus.u_tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_utx", bus.u_tx, 1'b1);
    check("async_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(W6);
    check("w6_busy_rise", bus.busy, 1'b1);
    run_word(1'b0, got, trace, bad);
    check("w6_anomalies", 128'(bad), 128'd0);
    check("w6_word", got, W6);
    check_done("w6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
